// File: rtl/block_plotter.sv
// Pixel stream generator for the moving block: erases the block at its last drawn
// position, then draws it at the newly latched position, one pixel per clock.
module block_plotter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned HEIGHT    = 4,
    parameter int unsigned X_MAX     = 160,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic [7:0] curr_x_position,
    input  logic [6:0] y_base,
    input  logic [2:0] colour,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       missed
);

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_t;

    state_t     state_q, state_d;
    logic [4:0] px_q, px_d;
    logic [3:0] py_q, py_d;
    logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d;
    logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d;
    logic [2:0] new_c_q, new_c_d;
    logic       prev_valid_q, prev_valid_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_out_q, colour_out_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d, missed_q, missed_d;

    logic       accept;
    logic       last_px, last_py;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_c;
    logic [8:0] sum_x;

    // The done cycle still counts as part of the frame, so a sync there is refused.
    assign accept  = sync && (state_q == StIdle) && !done_q;
    assign last_px = (px_q == 5'(WIDTH - 1));
    assign last_py = (py_q == 4'(HEIGHT - 1));
    assign base_x  = (state_q == StErase) ? old_x_q : new_x_q;
    assign base_y  = (state_q == StErase) ? old_y_q : new_y_q;
    assign base_c  = (state_q == StErase) ? BG_COLOUR : new_c_q;
    assign sum_x   = {1'b0, base_x} + {4'b0, px_q};

    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_c_d      = new_c_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        prev_valid_d = prev_valid_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        colour_out_d = colour_out_q;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        missed_d     = sync && !accept;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    new_x_d = curr_x_position;
                    new_y_d = y_base;
                    new_c_d = colour;
                    px_d    = '0;
                    py_d    = '0;
                    state_d = prev_valid_q ? StErase : StDraw;
                end
            end
            StErase, StDraw: begin
                x_out_d      = sum_x[7:0];
                y_out_d      = base_y + 7'(py_q);
                colour_out_d = base_c;
                plot_d       = ({23'd0, sum_x} < X_MAX);
                busy_d       = 1'b1;
                if (!last_px) begin
                    px_d = px_q + 5'd1;
                end else begin
                    px_d = '0;
                    if (!last_py) begin
                        py_d = py_q + 4'd1;
                    end else begin
                        py_d = '0;
                        if (state_q == StErase) begin
                            state_d = StDraw;
                        end else begin
                            old_x_d      = new_x_q;
                            old_y_d      = new_y_q;
                            prev_valid_d = 1'b1;
                            state_d      = StDone;
                        end
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            px_q         <= '0;
            py_q         <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            new_c_q      <= '0;
            old_x_q      <= '0;
            old_y_q      <= '0;
            prev_valid_q <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_c_q      <= new_c_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            prev_valid_q <= prev_valid_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            missed_q     <= missed_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign missed     = missed_q;

endmodule
